// File: rtl/serial_staticisor.sv
// Serial instruction staticisor: assembles an LSB-first word during the scan phase
// and transfers its line-address and function fields into held outputs at the action phase.
module serial_staticisor #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ADDR_LSB   = 0,
    parameter int FUNC_WIDTH = 3,
    parameter int FUNC_LSB   = 13
) (
    input  logic                  w_CLK,
    input  logic                  w_RSTn,
    input  logic                  ready,
    input  logic                  w_HA,
    input  logic                  w_BIT,
    input  logic                  w_BIT_VALID,
    input  logic                  w_WORD_START,
    input  logic                  w_MAN,
    input  logic [ADDR_WIDTH-1:0] b_MAN_ADDR,
    input  logic [FUNC_WIDTH-1:0] b_MAN_FUNC,
    output logic [ADDR_WIDTH-1:0] b_ADDR_OUT,
    output logic [FUNC_WIDTH-1:0] b_FUNC_OUT,
    output logic                  w_STAT_VALID,
    output logic                  w_SHORT
);

    localparam int CW   = $clog2(WORD_WIDTH + 1);
    localparam int IDXW = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, FULL, HOLD} state_e;

    state_e                  state_q;
    logic [CW-1:0]           count_q, count_d;
    logic [WORD_WIDTH-1:0]   word_q, word_d;
    logic [WORD_WIDTH-1:0]   first_word;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [FUNC_WIDTH-1:0]   func_q;
    logic                    valid_q;
    logic                    short_q;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        word_d                   = word_q;
        word_d[count_q[IDXW-1:0]] = w_BIT;
        count_d                  = count_q + 1'b1;
        first_word               = '0;
        first_word[0]            = w_BIT;
    end

    // NOTE: sequential state uses non-blocking assignments only; the shift register is
    // reset too, since the reset state defines it as zero.
    always_ff @(posedge w_CLK) begin
        if (!w_RSTn) begin
            state_q <= IDLE;
            count_q <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            func_q  <= '0;
            valid_q <= 1'b0;
            short_q <= 1'b0;
        end else begin
            // The short pulse self-clears even while ready is low.
            short_q <= 1'b0;
            if (ready) begin
                unique case (state_q)
                    HOLD: begin
                        if (!w_HA) begin
                            state_q <= IDLE;
                            count_q <= '0;
                        end
                    end
                    default: begin
                        if (w_HA) begin
                            state_q <= HOLD;
                            count_q <= '0;
                            word_q  <= '0;
                            if (w_MAN) begin
                                addr_q  <= b_MAN_ADDR;
                                func_q  <= b_MAN_FUNC;
                                valid_q <= 1'b1;
                            end else if (state_q == FULL) begin
                                addr_q  <= word_q[ADDR_LSB +: ADDR_WIDTH];
                                func_q  <= word_q[FUNC_LSB +: FUNC_WIDTH];
                                valid_q <= 1'b1;
                            end else begin
                                valid_q <= 1'b0;
                                short_q <= 1'b1;
                            end
                        end else if (w_BIT_VALID) begin
                            if (w_WORD_START) begin
                                word_q  <= first_word;
                                count_q <= CW'(1);
                                state_q <= SHIFT;
                            end else if (state_q == SHIFT) begin
                                word_q  <= word_d;
                                count_q <= count_d;
                                if (count_d == CW'(WORD_WIDTH)) begin
                                    state_q <= FULL;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign b_ADDR_OUT   = addr_q;
    assign b_FUNC_OUT   = func_q;
    assign w_STAT_VALID = valid_q;
    assign w_SHORT      = short_q;

endmodule

// File: doc/serial_staticisor.md
# serial_staticisor

Parametrised successor to the parallel staticisor. Assembles an instruction word arriving serially from the store, one bit per strobe, during the scan phase. At the start of the action phase it extracts configurable line-address and function fields into held outputs. A manual override and incomplete-word detection are included. Sits between the store read path and the line/function decoders of the control section.

## Interface
- WORD_WIDTH, 32, bits per serial instruction word (2–64)
- ADDR_WIDTH, 5, line-address field width
- ADDR_LSB, 0, word bit index of the address field LSB
- FUNC_WIDTH, 3, function field width
- FUNC_LSB, 13, word bit index of the function field LSB
- Constraint: both fields lie within WORD_WIDTH and do not overlap.

Ports:
- w_CLK  in  1  clock; all state changes on rising edge
- w_RSTn  in  1  synchronous, active-low reset; acts on any edge, independent of ready
- ready  in  1  clock enable for all non-reset updates
- w_HA  in  1  phase: 0 = scan (accept bits), 1 = action (transfer/hold)
- w_BIT  in  1  serial data bit
- w_BIT_VALID  in  1  w_BIT is valid this cycle
- w_WORD_START  in  1  qualifies the first bit of a word (meaningful only with w_BIT_VALID)
- w_MAN  in  1  manual mode: transfer loads manual inputs
- b_MAN_ADDR  in  ADDR_WIDTH  manual line address
- b_MAN_FUNC  in  FUNC_WIDTH  manual function
- b_ADDR_OUT  out  ADDR_WIDTH  staticised line address
- b_FUNC_OUT  out  FUNC_WIDTH  staticised function
- w_STAT_VALID  out  1  outputs hold a successfully transferred word
- w_SHORT  out  1  one-cycle pulse: transfer attempted with an incomplete word

## Operation
- Reset values: b_ADDR_OUT=0, b_FUNC_OUT=0, w_STAT_VALID=0, w_SHORT=0, state IDLE, bit counter 0, shift register 0.
- Bit order: the k-th accepted bit (k=0 first) becomes word bit k, so bits arrive LSB first.
- Bits are accepted only when ready=1, w_HA=0 and w_BIT_VALID=1.
- States:
  - IDLE: an accepted bit with w_WORD_START=1 stores bit 0, sets count=1 and moves to SHIFT. Accepted bits without w_WORD_START are ignored.
  - SHIFT: each accepted bit stores at index count, then count++. When count reaches WORD_WIDTH, go to FULL. An accepted bit with w_WORD_START=1 restarts: store bit 0, count=1, no error.
  - FULL: further accepted bits are ignored unless w_WORD_START=1, which restarts as in SHIFT and returns to SHIFT.
  - HOLD: outputs frozen; on w_HA=0 go to IDLE, count=0. Bits presented in that same cycle are not accepted.
- Transfer takes place on the first ready edge with w_HA=1 in IDLE, SHIFT or FULL, then the block enters HOLD:
  - w_MAN=1: load b_MAN_ADDR/b_MAN_FUNC, set w_STAT_VALID=1, no w_SHORT, regardless of state.
  - w_MAN=0 and FULL: load word[ADDR_LSB +: ADDR_WIDTH] and word[FUNC_LSB +: FUNC_WIDTH], set w_STAT_VALID=1.
  - w_MAN=0 and IDLE/SHIFT: outputs unchanged, w_STAT_VALID=0, w_SHORT=1 for one cycle, partial word discarded.
- Outputs are not cleared on leaving the action phase; they persist until the next transfer or reset.
- While ready=0, all state, counters and outputs are frozen. w_SHORT is forced to 0 on the cycle after its pulse, even if ready=0.

## Timing
- Transfer latency: outputs and w_STAT_VALID change at the first qualifying edge with w_HA=1. They are visible one cycle after w_HA is sampled high.
- The last bit and w_HA=1 must not coincide. Bits are not accepted while w_HA=1, so that case yields a short word.
- Minimum scan phase: WORD_WIDTH accepted cycles. There is no cap on idle cycles between bits.
- Reset mid-word or mid-hold returns to the reset state at that edge. w_HA still high after reset is treated as a transfer attempt from IDLE, producing w_SHORT unless w_MAN=1.

## Test plan
- Reset, then serial word 0x00006007 (32 bits, start on bit 0), then w_HA=1 -> b_ADDR_OUT=7, b_FUNC_OUT=3, w_STAT_VALID=1 one cycle after w_HA sampled; outputs unchanged after w_HA falls.
- Only 20 bits shifted, then w_HA=1 with prior outputs 7/3 -> w_SHORT pulses exactly 1 cycle, w_STAT_VALID=0, outputs remain 7/3.
- w_MAN=1, b_MAN_ADDR=31, b_MAN_FUNC=5, w_HA=1 from IDLE -> outputs 31/5, w_STAT_VALID=1, w_SHORT=0.
- 10 bits of garbage, then w_WORD_START with 0x0000A01F -> after transfer, ADDR=31, FUNC=5 (restart honoured).
- ready toggled 0 on alternate cycles during a shift of 0xFFFFFFFF, and bits with w_BIT_VALID=0 interleaved -> only enabled valid bits count; ADDR=31, FUNC=7.
- w_RSTn=0 for one edge at bit 17 of a word, then w_HA=1 -> all outputs 0, w_SHORT=1 one cycle.
